// File: rtl/meal_scheduler_if.sv
// Control/status bundle between the feeder scheduler and its host:
// current time, slot programming, feed requests, motor drive and status.
interface meal_scheduler_if #(
  parameter int unsigned IDX_W = 2
);
  logic             sec_tick;
  logic [3:0]       chour2, chour1, cminute2, cminute1, csecond2, csecond1;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [3:0]       wr_hour2, wr_hour1, wr_minute2, wr_minute1;
  logic [1:0]       wr_portions;
  logic             wr_enable;
  logic             manual_feed;
  logic             abort;
  logic             ME, MT1, MT2;
  logic             beep;
  logic             busy;
  logic             feed_done;
  logic             missed;
  logic [7:0]       fed_count;
  logic [4:0]       state_code;

  modport master (
    output sec_tick, chour2, chour1, cminute2, cminute1, csecond2, csecond1,
           wr_en, wr_idx, wr_hour2, wr_hour1, wr_minute2, wr_minute1,
           wr_portions, wr_enable, manual_feed, abort,
    input  ME, MT1, MT2, beep, busy, feed_done, missed, fed_count, state_code
  );

  modport slave (
    input  sec_tick, chour2, chour1, cminute2, cminute1, csecond2, csecond1,
           wr_en, wr_idx, wr_hour2, wr_hour1, wr_minute2, wr_minute1,
           wr_portions, wr_enable, manual_feed, abort,
    output ME, MT1, MT2, beep, busy, feed_done, missed, fed_count, state_code
  );
endinterface

// File: rtl/meal_scheduler.sv
// Pet-feeder scheduler: programmable meal slots trigger beep / motor-forward /
// anti-jam-reverse sequences per portion, with a one-deep request queue.
module meal_scheduler #(
  parameter int unsigned NUM_MEALS   = 4,
  parameter int unsigned IDX_W       = 2,
  parameter int unsigned BEEP_CYCLES = 50000000,
  parameter int unsigned FWD_CYCLES  = 100000000,
  parameter int unsigned REV_CYCLES  = 2333333
) (
  input  logic             iCLK,
  input  logic             iRST,
  meal_scheduler_if.slave  bus
);
  localparam int unsigned MAX_A   = (BEEP_CYCLES > FWD_CYCLES) ? BEEP_CYCLES : FWD_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_A > REV_CYCLES) ? MAX_A : REV_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] BEEP_LAST = CNT_W'(BEEP_CYCLES - 1);
  localparam logic [CNT_W-1:0] FWD_LAST  = CNT_W'(FWD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REV_LAST  = CNT_W'(REV_CYCLES - 1);

  typedef enum logic [4:0] {
    S_IDLE = 5'b00001,
    S_BEEP = 5'b00010,
    S_FWD  = 5'b00100,
    S_REV  = 5'b01000,
    S_DONE = 5'b10000
  } state_t;

  typedef struct packed {
    logic [3:0] h2, h1, m2, m1;
    logic [1:0] por;
    logic       en;
  } slot_t;

  slot_t            slots [NUM_MEALS];
  state_t           state;
  logic [4:0]       outs;      // {ME, MT1, MT2, beep, busy}
  logic [CNT_W-1:0] cyc;
  logic [1:0]       portion;
  logic             pend_v;
  logic [1:0]       pend_por;
  logic             done_r;
  logic             missed_r;
  logic [7:0]       fed;
  logic             hit;
  logic [1:0]       hit_por;
  logic             req_a, req_b;
  logic [1:0]       por_a;

  function automatic logic [4:0] drive(state_t s);
    case (s)
      S_BEEP:  return 5'b00011;
      S_FWD:   return 5'b11001;
      S_REV:   return 5'b10101;
      S_DONE:  return 5'b00001;
      default: return 5'b00000;
    endcase
  endfunction

  // Lowest-index matching slot wins; only checked at the top of a minute.
  always_comb begin
    hit     = 1'b0;
    hit_por = '0;
    if (bus.sec_tick && bus.csecond2 == 4'd0 && bus.csecond1 == 4'd0) begin
      for (int unsigned i = 0; i < NUM_MEALS; i++) begin
        if (!hit && slots[i].en && slots[i].h2 == bus.chour2 && slots[i].h1 == bus.chour1 &&
            slots[i].m2 == bus.cminute2 && slots[i].m1 == bus.cminute1) begin
          hit     = 1'b1;
          hit_por = slots[i].por;
        end
      end
    end
  end

  // A coincident manual request ranks behind the slot trigger.
  assign req_a = hit | bus.manual_feed;
  assign por_a = hit ? hit_por : 2'd0;
  assign req_b = hit & bus.manual_feed;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state    <= S_IDLE;
      outs     <= '0;
      cyc      <= '0;
      portion  <= '0;
      pend_v   <= 1'b0;
      pend_por <= '0;
      done_r   <= 1'b0;
      missed_r <= 1'b0;
      fed      <= '0;
      for (int unsigned i = 0; i < NUM_MEALS; i++) slots[i] <= '0;
    end else begin
      if (bus.wr_en && 32'(bus.wr_idx) < NUM_MEALS)
        slots[bus.wr_idx] <= {bus.wr_hour2, bus.wr_hour1, bus.wr_minute2, bus.wr_minute1,
                              bus.wr_portions, bus.wr_enable};
      done_r <= 1'b0;
      if (bus.abort) begin
        state    <= S_IDLE;
        outs     <= '0;
        cyc      <= '0;
        portion  <= '0;
        pend_v   <= 1'b0;
        pend_por <= '0;
      end else begin
        if ((state == S_BEEP || state == S_FWD || state == S_REV) && req_a) begin
          if (!pend_v) begin
            pend_v   <= 1'b1;
            pend_por <= por_a;
            if (req_b) missed_r <= 1'b1;
          end else begin
            missed_r <= 1'b1;
          end
        end
        case (state)
          S_BEEP: begin
            if (cyc == BEEP_LAST) begin
              state <= S_FWD;
              outs  <= drive(S_FWD);
              cyc   <= '0;
            end else cyc <= cyc + 1'b1;
          end
          S_FWD: begin
            if (cyc == FWD_LAST) begin
              state <= S_REV;
              outs  <= drive(S_REV);
              cyc   <= '0;
            end else cyc <= cyc + 1'b1;
          end
          S_REV: begin
            if (cyc == REV_LAST) begin
              cyc <= '0;
              if (portion != 2'd0) begin
                portion <= portion - 2'd1;
                state   <= S_FWD;
                outs    <= drive(S_FWD);
              end else begin
                state  <= S_DONE;
                outs   <= drive(S_DONE);
                done_r <= 1'b1;
                if (fed != 8'hFF) fed <= fed + 8'd1;
              end
            end else cyc <= cyc + 1'b1;
          end
          default: begin
            // IDLE, and DONE with nothing queued, accept new requests directly;
            // DONE with a queued request starts it and drops anything new.
            if (state == S_DONE && pend_v) begin
              state   <= S_BEEP;
              outs    <= drive(S_BEEP);
              cyc     <= '0;
              portion <= pend_por;
              pend_v  <= 1'b0;
              if (req_a) missed_r <= 1'b1;
            end else if (req_a) begin
              state   <= S_BEEP;
              outs    <= drive(S_BEEP);
              cyc     <= '0;
              portion <= por_a;
              if (req_b) begin
                pend_v   <= 1'b1;
                pend_por <= 2'd0;
              end
            end else begin
              state <= S_IDLE;
              outs  <= drive(S_IDLE);
            end
          end
        endcase
      end
    end
  end

  assign {bus.ME, bus.MT1, bus.MT2, bus.beep, bus.busy} = outs;
  assign bus.state_code = state;
  assign bus.feed_done  = done_r;
  assign bus.missed     = missed_r;
  assign bus.fed_count  = fed;
endmodule

// File: tb/tb_meal_scheduler.sv
// Bench for meal_scheduler: a feed-timeline model predicts every output each
// cycle, and directed scenarios add literal checks on top.
module tb_meal_scheduler;
  localparam int NM = 4, BC = 4, FC = 10, RC = 3;

  logic iCLK = 1'b0;
  logic iRST = 1'b1;
  always #5 iCLK = ~iCLK;

  meal_scheduler_if #(.IDX_W(2)) bus ();
  meal_scheduler #(.NUM_MEALS(NM), .IDX_W(2), .BEEP_CYCLES(BC), .FWD_CYCLES(FC),
                   .REV_CYCLES(RC)) dut (.iCLK(iCLK), .iRST(iRST), .bus(bus));

  int vectors = 0, miscompares = 0, done_seen = 0;

  // Model: a feed is a timeline of BC beep cycles, (FC+RC) per portion, then one done cycle.
  bit m_ready = 0, m_act = 0, m_miss = 0, pv = 0;
  int m_off = 0, m_len = 0, m_fed = 0, pp = 0;
  int s_h2[NM], s_h1[NM], s_m2[NM], s_m1[NM], s_por[NM], s_en[NM];

  function automatic void start_feed(int p);
    m_act = 1; m_off = 0; m_len = BC + (FC + RC) * (p + 1) + 1;
  endfunction

  function automatic void model_step();
    int q[$];
    if (iRST) begin
      m_ready = 1; m_act = 0; pv = 0; pp = 0; m_fed = 0; m_miss = 0;
      for (int i = 0; i < NM; i++) begin
        s_h2[i] = 0; s_h1[i] = 0; s_m2[i] = 0; s_m1[i] = 0; s_por[i] = 0; s_en[i] = 0;
      end
      return;
    end
    if (bus.sec_tick && bus.csecond2 == 0 && bus.csecond1 == 0) begin
      for (int i = 0; i < NM; i++) begin
        if (s_en[i] != 0 && s_h2[i] == int'(bus.chour2) && s_h1[i] == int'(bus.chour1) &&
            s_m2[i] == int'(bus.cminute2) && s_m1[i] == int'(bus.cminute1)) begin
          q.push_back(s_por[i]);
          break;
        end
      end
    end
    if (bus.manual_feed) q.push_back(0);
    if (bus.abort) begin
      m_act = 0; pv = 0;
    end else if (!m_act || (m_off == m_len - 1 && !pv)) begin
      if (q.size() > 0) begin
        start_feed(q[0]);
        if (q.size() > 1) begin pv = 1; pp = q[1]; end
      end else m_act = 0;
    end else if (m_off == m_len - 1) begin
      start_feed(pp); pv = 0;
      if (q.size() > 0) m_miss = 1;
    end else begin
      m_off++;
      foreach (q[j]) begin
        if (!pv) begin pv = 1; pp = q[j]; end
        else m_miss = 1;
      end
      if (m_off == m_len - 1 && m_fed < 255) m_fed++;
    end
    if (bus.wr_en) begin
      int k = int'(bus.wr_idx);
      s_h2[k] = bus.wr_hour2; s_h1[k] = bus.wr_hour1; s_m2[k] = bus.wr_minute2;
      s_m1[k] = bus.wr_minute1; s_por[k] = bus.wr_portions; s_en[k] = bus.wr_enable;
    end
  endfunction

  function automatic logic [17:0] expected();
    logic [4:0] code = 5'b00001;
    logic me = 0, t1 = 0, t2 = 0, bp = 0, bz = 0, dn = 0;
    int k;
    if (m_act) begin
      bz = 1;
      if (m_off < BC) begin code = 5'b00010; bp = 1; end
      else if (m_off == m_len - 1) begin code = 5'b10000; dn = 1; end
      else begin
        k = (m_off - BC) % (FC + RC);
        if (k < FC) begin code = 5'b00100; me = 1; t1 = 1; end
        else begin code = 5'b01000; me = 1; t2 = 1; end
      end
    end
    return {code, me, t1, t2, bp, bz, dn, m_miss, 8'(m_fed)};
  endfunction

  initial begin
    logic [17:0] exp_v, act_v;
    forever begin
      @(posedge iCLK);
      model_step();
      @(negedge iCLK);
      if (m_ready) begin
        exp_v = expected();
        act_v = {bus.state_code, bus.ME, bus.MT1, bus.MT2, bus.beep, bus.busy,
                 bus.feed_done, bus.missed, bus.fed_count};
        vectors++;
        if (act_v !== exp_v) begin
          miscompares++;
          $display("FAIL cycle_model t=%0t got %b expected %b", $time, act_v, exp_v);
        end
        vectors++;
        if (bus.MT1 === 1'b1 && bus.MT2 === 1'b1) begin
          miscompares++;
          $display("FAIL motor_excl t=%0t got MT1=1 MT2=1 expected not both 1", $time);
        end
        if (bus.feed_done === 1'b1) done_seen++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t got no finish expected finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic step(int n = 1);
    repeat (n) begin @(posedge iCLK); #1; end
  endtask

  task automatic write_slot(int idx, int h2, int h1, int m2, int m1, int por, int en);
    bus.wr_idx = 2'(idx); bus.wr_hour2 = 4'(h2); bus.wr_hour1 = 4'(h1);
    bus.wr_minute2 = 4'(m2); bus.wr_minute1 = 4'(m1); bus.wr_portions = 2'(por);
    bus.wr_enable = 1'(en); bus.wr_en = 1'b1;
    step(); bus.wr_en = 1'b0;
  endtask

  task automatic set_time(int h2, int h1, int m2, int m1, int s2, int s1);
    bus.chour2 = 4'(h2); bus.chour1 = 4'(h1); bus.cminute2 = 4'(m2);
    bus.cminute1 = 4'(m1); bus.csecond2 = 4'(s2); bus.csecond1 = 4'(s1);
  endtask

  task automatic tick();
    bus.sec_tick = 1'b1; step(); bus.sec_tick = 1'b0;
  endtask

  task automatic manual();
    bus.manual_feed = 1'b1; step(); bus.manual_feed = 1'b0;
  endtask

  task automatic run_busy(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 500) begin n++; step(); end
    if (n >= 500) check("busy_timeout", 32'(n), 32'd0);
  endtask

  task automatic wait_state(logic [4:0] code);
    int n = 0;
    while (bus.state_code !== code && n < 500) begin n++; step(); end
    if (n >= 500) check("state_timeout", 32'(bus.state_code), 32'(code));
  endtask

  initial begin
    int n, d0;
    bus.sec_tick = 0; bus.wr_en = 0; bus.wr_idx = '0; bus.wr_hour2 = 0; bus.wr_hour1 = 0;
    bus.wr_minute2 = 0; bus.wr_minute1 = 0; bus.wr_portions = 0; bus.wr_enable = 0;
    bus.manual_feed = 0; bus.abort = 0;
    set_time(0, 0, 0, 0, 0, 0);
    step(2);
    iRST = 1'b0;
    check("rst_state", 32'(bus.state_code), 32'd1);
    check("rst_fed", 32'(bus.fed_count), 32'd0);
    check("rst_missed", 32'(bus.missed), 32'd0);

    // Slot 2 at 07:30, two portions
    write_slot(2, 0, 7, 3, 0, 1, 1);
    set_time(0, 7, 3, 0, 0, 0);
    d0 = done_seen;
    tick();
    check("two_por_first_beep", 32'(bus.state_code), 32'd2);
    run_busy(n);
    check("two_por_len", 32'(n), 32'd31);
    check("two_por_done", 32'(done_seen - d0), 32'd1);
    check("two_por_fed", 32'(bus.fed_count), 32'd1);

    // Slots 1 and 3 both at 12:00; slot 1 (one portion) must win
    write_slot(1, 1, 2, 0, 0, 0, 1);
    write_slot(3, 1, 2, 0, 0, 3, 1);
    set_time(1, 2, 0, 0, 0, 0);
    tick();
    run_busy(n);
    check("lowest_idx_len", 32'(n), 32'd18);
    check("lowest_idx_fed", 32'(bus.fed_count), 32'd2);
    set_time(1, 2, 0, 0, 0, 1);
    tick();
    step(3);
    check("sec01_no_trig", 32'(bus.busy), 32'd0);

    // Abort on 5th FWD clock with a queued request and a coincident request
    d0 = done_seen;
    manual();
    step();
    manual();
    wait_state(5'b00100);
    step(4);
    bus.abort = 1'b1; bus.manual_feed = 1'b1;
    step();
    bus.abort = 1'b0; bus.manual_feed = 1'b0;
    check("abort_state", 32'(bus.state_code), 32'd1);
    check("abort_motor", 32'({bus.ME, bus.MT1, bus.MT2}), 32'd0);
    check("abort_done", 32'(bus.feed_done), 32'd0);
    step(25);
    check("abort_pend_clr", 32'(bus.busy), 32'd0);
    check("abort_missed", 32'(bus.missed), 32'd0);
    check("abort_fed", 32'(bus.fed_count), 32'd2);
    check("abort_no_done", 32'(done_seen - d0), 32'd0);

    // Three manual requests: run, queue, drop
    d0 = done_seen;
    manual();
    step(2);
    manual();
    step(2);
    check("queue_missed0", 32'(bus.missed), 32'd0);
    manual();
    check("queue_missed1", 32'(bus.missed), 32'd1);
    wait_state(5'b10000);
    step();
    check("done_to_beep", 32'(bus.state_code), 32'd2);
    run_busy(n);
    check("queue_fed", 32'(bus.fed_count), 32'd4);
    check("queue_dones", 32'(done_seen - d0), 32'd2);

    // Reset during REV clears slots and counters
    set_time(0, 7, 3, 0, 0, 0);
    tick();
    wait_state(5'b01000);
    iRST = 1'b1;
    step();
    check("midrst_state", 32'(bus.state_code), 32'd1);
    check("midrst_outs", 32'({bus.ME, bus.MT1, bus.MT2, bus.beep, bus.busy, bus.feed_done}), 32'd0);
    check("midrst_missed", 32'(bus.missed), 32'd0);
    check("midrst_fed", 32'(bus.fed_count), 32'd0);
    iRST = 1'b0;
    tick();
    step(3);
    check("midrst_no_trig", 32'(bus.busy), 32'd0);

    // 256 manual feeds saturate fed_count
    d0 = done_seen;
    for (int i = 0; i < 256; i++) begin
      manual();
      run_busy(n);
    end
    check("sat_fed", 32'(bus.fed_count), 32'd255);
    check("sat_dones", 32'(done_seen - d0), 32'd256);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
